// File: rtl/systolic_drv_pkg.sv
// rtl/systolic_drv_pkg.sv - shared types and width helpers for the systolic stimulus driver
//
// Purpose: sweep state encoding plus width helpers used by systolic_stim_driver
//          and systolic_nor_model.
// Contents:
//   drvState_t   - IDLE / APPLY / EMIT / DONE
//   vecWidth     - N = ROW + COLUMN, width of the swept vector
//   countWidth   - N + 1, wide enough to hold 2^N sampled ones
//   settleWidth  - $clog2(SETTLE + 1), width of the settle counter
package systolic_drv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } drvState_t;

   function automatic int vecWidth(input int row, input int column);
      return row + column;
   endfunction

   function automatic int countWidth(input int row, input int column);
      return row + column + 1;
   endfunction

   function automatic int settleWidth(input int settle);
      return $clog2(settle + 1);
   endfunction

endpackage

// File: rtl/systolic_nor_model.sv
// rtl/systolic_nor_model.sv - combinational golden ROW x COLUMN NOR array
//
// Purpose: reference array used to cross-check the external array output.
//          Each cell is NOR(left, up); inRow[i] is the left input of row i,
//          inColumn[j] is the upper input of column j, out is the bottom-right cell.
// Ports:
//   inRow     in   ROW     row inputs, feed column 0
//   inColumn  in   COLUMN  column inputs, feed row 0
//   out       out  1       value of cell [ROW-1][COLUMN-1]
module systolic_nor_model
   import systolic_drv_pkg::*;
#(
   parameter int ROW    = 4,
   parameter int COLUMN = 11
) (
   input  logic [ROW-1:0]    inRow,
   input  logic [COLUMN-1:0] inColumn,
   output logic              out
);

   // Rows are evaluated top to bottom; prevRow carries the cells of the row
   // above so every cell sees its "up" neighbour without a 2-D net.
   always_comb begin
      logic [COLUMN-1:0] prevRow;
      logic [COLUMN-1:0] curRow;
      logic              leftVal;
      logic              upVal;
      prevRow = inColumn;
      curRow  = '0;
      for (int i = 0; i < ROW; i++) begin
         leftVal = inRow[i];
         for (int j = 0; j < COLUMN; j++) begin
            upVal     = prevRow[j];
            curRow[j] = ~(leftVal | upVal);
            leftVal   = curRow[j];
         end
         prevRow = curRow;
      end
      out = prevRow[COLUMN-1];
   end

endmodule

// File: rtl/systolic_stim_driver.sv
// rtl/systolic_stim_driver.sv - exhaustive stimulus sweep and result capture for a NOR array
//
// Purpose: drives {in_row,in_column} through 0 .. 2^N-1, holds each vector for
//          SETTLE cycles, samples dut_out and streams (vector, bit) over a
//          valid/ready handshake while counting sampled ones.
// Optional: SYSTOLIC_DRV_CHECK_EN adds an internal golden NOR model plus the
//           mismatch / mismatch_count outputs.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a sweep (honoured only in IDLE)
//   busy, done      sweep in progress / one-cycle completion pulse
//   in_row          row vector to the array (upper ROW bits of V)
//   in_column       column vector to the array (lower COLUMN bits of V)
//   dut_out         array output
//   res_valid       result available; res_ready accepts it
//   res_vec         vector that produced res_bit
//   res_bit         sampled dut_out
//   ones_count      sampled ones in the current or last sweep
//   mismatch        (optional) model and dut_out differed for this result
//   mismatch_count  (optional) mismatching samples in this sweep
module systolic_stim_driver
   import systolic_drv_pkg::*;
#(
   parameter int ROW    = 4,
   parameter int COLUMN = 11,
   parameter int SETTLE = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ROW-1:0]        in_row,
   output logic [COLUMN-1:0]     in_column,
   input  logic                  dut_out,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [ROW+COLUMN-1:0] res_vec,
   output logic                  res_bit,
   output logic [ROW+COLUMN:0]   ones_count
`ifdef SYSTOLIC_DRV_CHECK_EN
   ,
   output logic                  mismatch,
   output logic [ROW+COLUMN:0]   mismatch_count
`endif
);

   localparam int N  = vecWidth(ROW, COLUMN);
   localparam int CW = countWidth(ROW, COLUMN);
   localparam int SW = settleWidth(SETTLE);

   drvState_t         stateReg;
   drvState_t         stateNext;
   logic [N-1:0]      vecReg;
   logic [SW-1:0]     settleCnt;
   logic              settleLast;
   logic              lastVec;

   assign in_row     = vecReg[N-1:COLUMN];
   assign in_column  = vecReg[COLUMN-1:0];
   assign settleLast = (settleCnt == SW'(1));
   assign lastVec    = (vecReg == {N{1'b1}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stateReg <= IDLE;
      else     stateReg <= stateNext;
   end

   always_comb begin
      stateNext = stateReg;
      busy      = 1'b0;
      done      = 1'b0;
      res_valid = 1'b0;
      case (stateReg)
         IDLE: begin
            if (start) stateNext = APPLY;
         end
         APPLY: begin
            busy = 1'b1;
            if (settleLast) stateNext = EMIT;
         end
         EMIT: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            if (res_ready) stateNext = lastVec ? DONE : APPLY;
         end
         DONE: begin
            done      = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

`ifdef SYSTOLIC_DRV_CHECK_EN
   logic modelOut;

   systolic_nor_model #(
      .ROW    (ROW),
      .COLUMN (COLUMN)
   ) uModel (
      .inRow    (in_row),
      .inColumn (in_column),
      .out      (modelOut)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mismatch       <= 1'b0;
         mismatch_count <= '0;
      end else if (stateReg == IDLE && start) begin
         mismatch_count <= '0;
      end else if (stateReg == APPLY && settleLast) begin
         mismatch <= (modelOut != dut_out);
         if (modelOut != dut_out) mismatch_count <= mismatch_count + CW'(1);
      end
   end
`else
   // No golden model in this build; the sweep datapath below is unaffected.
`endif

   // V only moves on the edge leaving EMIT, so the array inputs are steady
   // for the whole settle window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vecReg     <= '0;
         settleCnt  <= '0;
         res_vec    <= '0;
         res_bit    <= 1'b0;
         ones_count <= '0;
      end else begin
         case (stateReg)
            IDLE: begin
               if (start) begin
                  vecReg     <= '0;
                  ones_count <= '0;
                  settleCnt  <= SW'(SETTLE);
               end
            end
            APPLY: begin
               if (settleLast) begin
                  res_bit <= dut_out;
                  res_vec <= vecReg;
                  if (dut_out) ones_count <= ones_count + CW'(1);
               end else begin
                  settleCnt <= settleCnt - SW'(1);
               end
            end
            EMIT: begin
               if (res_ready && !lastVec) begin
                  vecReg    <= vecReg + N'(1);
                  settleCnt <= SW'(SETTLE);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_stim_driver.sv
// tb/tb_systolic_stim_driver.sv - self-checking bench for systolic_stim_driver
//
// Purpose: the array is modelled as a truth table indexed by {in_row,in_column};
//          each sweep checks vector order, sampled bits, ones_count, done timing,
//          backpressure, ignored starts and mid-sweep reset.
// Optional: SYSTOLIC_DRV_CHECK_EN also checks mismatch / mismatch_count.
module tb_systolic_stim_driver;

   localparam int ROW      = 2;
   localparam int COLUMN   = 2;
   localparam int SETTLE   = 2;
   localparam int N        = ROW + COLUMN;
   localparam int NVEC     = 2 ** N;
   localparam int DONE_CYC = NVEC * (SETTLE + 1) + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              busy;
   logic              done;
   logic [ROW-1:0]    in_row;
   logic [COLUMN-1:0] in_column;
   logic              dut_out;
   logic              res_valid;
   logic              res_ready;
   logic [N-1:0]      res_vec;
   logic              res_bit;
   logic [N:0]        ones_count;
`ifdef SYSTOLIC_DRV_CHECK_EN
   logic              mismatch;
   logic [N:0]        mismatch_count;
`endif

   logic [NVEC-1:0]   tbl;
   int                checks = 0;
   int                errors = 0;

   assign dut_out = tbl[{in_row, in_column}];

   always #5 clk = ~clk;

   systolic_stim_driver #(
      .ROW    (ROW),
      .COLUMN (COLUMN),
      .SETTLE (SETTLE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .in_row     (in_row),
      .in_column  (in_column),
      .dut_out    (dut_out),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_vec    (res_vec),
      .res_bit    (res_bit),
      .ones_count (ones_count)
`ifdef SYSTOLIC_DRV_CHECK_EN
      ,
      .mismatch       (mismatch),
      .mismatch_count (mismatch_count)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Golden array evaluated straight from the cell rule NOR(left, up).
   function automatic bit norRef(input int v);
      bit g[ROW][COLUMN];
      bit l;
      bit u;
      for (int i = 0; i < ROW; i++) begin
         for (int j = 0; j < COLUMN; j++) begin
            if (j == 0) l = bit'((v >> (COLUMN + i)) & 1);
            else        l = g[i][j-1];
            if (i == 0) u = bit'((v >> j) & 1);
            else        u = g[i-1][j];
            g[i][j] = ~(l | u);
         end
      end
      return g[ROW-1][COLUMN-1];
   endfunction

   function automatic int refMismatches();
      int n = 0;
      for (int v = 0; v < NVEC; v++) if (tbl[v] != norRef(v)) n++;
      return n;
   endfunction

   task automatic randomTable();
      for (int v = 0; v < NVEC; v++) tbl[v] = 1'($urandom % 2);
   endtask

   // One sweep: start is pulsed, results are checked one by one against tbl.
   task automatic runSweep(input bit randomReady, input int abortVec,
                           input int extraStartVec, input bit checkTiming);
      int expIdx   = 0;
      int cycleNo  = 0;
      int holdLow  = 0;
      int results  = 0;
      bit sawDone  = 0;
      bit aborted  = 0;
      bit sentExtra = 0;
      start     = 1'b1;
      res_ready = 1'b1;
      @(negedge clk);
      cycleNo = 1;
      chk("ones_cleared", ones_count, 0);
`ifdef SYSTOLIC_DRV_CHECK_EN
      chk("mismatch_cleared", mismatch_count, 0);
`endif
      while (!sawDone && !aborted && cycleNo < 2000) begin
         start = 1'b0;
         if (busy) chk("pins", {in_row, in_column}, expIdx);
         if (res_valid) begin
            chk("res_vec", res_vec, expIdx);
            chk("res_bit", res_bit, tbl[expIdx]);
`ifdef SYSTOLIC_DRV_CHECK_EN
            chk("mismatch", mismatch, tbl[expIdx] != norRef(expIdx));
`endif
         end
         if (done) begin
            sawDone = 1;
         end else if (abortVec >= 0 && busy && !res_valid && expIdx == abortVec) begin
            rst = 1'b1;
            #1;
            chk("abort_ctrl", {busy, done, res_valid, res_bit}, 0);
            chk("abort_data", {res_vec, ones_count, in_row, in_column}, 0);
            @(negedge clk);
            chk("abort_idle", {busy, done, res_valid}, 0);
            rst = 1'b0;
            aborted = 1;
         end else begin
            if (extraStartVec >= 0 && expIdx == extraStartVec && busy && !sentExtra) begin
               start = 1'b1;
               sentExtra = 1;
            end
            if (randomReady) begin
               if (expIdx == 3 && res_valid && holdLow < 5) begin
                  res_ready = 1'b0;
                  holdLow++;
               end else begin
                  res_ready = 1'($urandom % 2);
               end
            end else begin
               res_ready = 1'b1;
            end
            if (res_valid && res_ready) begin
               results++;
               expIdx++;
            end
            @(negedge clk);
            cycleNo++;
         end
      end
      start = 1'b0;
      if (!aborted) begin
         chk("done_seen", sawDone, 1);
         if (sawDone) begin
            chk("result_count", results, NVEC);
            chk("ones_count", ones_count, $countones(tbl));
            if (checkTiming) chk("done_cycle", cycleNo, DONE_CYC);
            if (randomReady) chk("backpressure_len", holdLow, 5);
`ifdef SYSTOLIC_DRV_CHECK_EN
            chk("mismatch_count", mismatch_count, refMismatches());
`endif
            @(negedge clk);
            chk("done_pulse", {done, busy}, 0);
            chk("final_vec", {in_row, in_column}, NVEC - 1);
            chk("ones_hold", ones_count, $countones(tbl));
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      res_ready = 1'b0;
      tbl       = '0;
      repeat (2) @(negedge clk);
      chk("reset_ctrl", {busy, done, res_valid, res_bit}, 0);
      chk("reset_data", {res_vec, ones_count, in_row, in_column}, 0);
      rst = 1'b0;
      @(negedge clk);

      tbl = '1;
      runSweep(1'b0, -1, -1, 1'b1);

      tbl = '0;
      runSweep(1'b0, -1, -1, 1'b1);

      randomTable();
      runSweep(1'b1, -1, 5, 1'b0);

      randomTable();
      runSweep(1'b1, 7, -1, 1'b0);

      randomTable();
      runSweep(1'b0, -1, -1, 1'b1);

`ifdef SYSTOLIC_DRV_CHECK_EN
      for (int v = 0; v < NVEC; v++) tbl[v] = norRef(v);
      runSweep(1'b0, -1, -1, 1'b1);
      tbl = '0;
      runSweep(1'b1, -1, -1, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
